// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle doubleword data memory for the pipelined
// LEGv8 core. Accepts one load/store at a time over a valid/ready request
// channel, waits LATENCY cycles, performs the access on a single edge and
// holds the response until the consumer takes it. busy stalls the pipeline.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic [31:0] op_count,
    output logic [15:0] err_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] op_q, op_d;
    logic [15:0] errc_q, errc_d;

    // Storage array is deliberately left uninitialised by reset.
    logic [63:0] mem_q [DEPTH];

    logic          mem_we;
    logic [AW-1:0] idx;
    logic          acc_err;

    // Error counter sticks at its maximum instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Decode the latched address: doubleword index and misaligned/out-of-range flag.
    always_comb begin
        idx     = addr_q[AW+2:3];
        acc_err = (addr_q[2:0] != 3'b000) || (addr_q[63:AW+3] != '0);
    end

    // Next-state, access and handshake outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        op_d       = op_q;
        errc_d     = errc_q;
        mem_we     = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // The access itself: counts every attempt, errors never touch the array.
                    op_d = op_q + 32'd1;
                    if (acc_err) begin
                        rdata_d = 64'd0;
                        err_d   = 1'b1;
                        errc_d  = sat_inc16(errc_q);
                    end else begin
                        err_d = 1'b0;
                        if (write_q) begin
                            mem_we  = 1'b1;
                            rdata_d = 64'd0;
                        end else begin
                            rdata_d = mem_q[idx];
                        end
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                busy       = 1'b1;
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and visible-output registers; reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
            op_q    <= 32'd0;
            errc_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            op_q    <= op_d;
            errc_q  <= errc_d;
        end
    end

    // Latched request payload; only meaningful after acceptance, so no reset.
    always_ff @(posedge clk) begin
        write_q <= write_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // Array write on the access edge; suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[idx] <= wdata_q;
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign op_count   = op_q;
    assign err_count  = errc_q;

endmodule
